cond_exec_ctrl: RTL and testbench

COND_EXEC_CTRL -- requirements
Module: cond_exec_ctrl

---
 rtl/cond_exec_ctrl.sv | 138 +++++++++++++
 tb/tb_cond_exec_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cond_exec_ctrl.sv
// ARM-style conditional-execution issue controller: flag scoreboard, condition check, stall/flush FSM.
// stall/issue/exec_en/flush are combinational in the ID cycle; status_reg and pending_cnt update one edge later.
module cond_exec_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [3:0] id_cond,
  input  logic       id_s,
  input  logic       id_is_branch,
  input  logic       hz_stall,
  input  logic       exe_flags_valid,
  input  logic [3:0] exe_flags,
  output logic [3:0] status_reg,
  output logic       stall,
  output logic       issue,
  output logic       exec_en,
  output logic       branch_taken,
  output logic       flush,
  output logic [1:0] pending_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] exe_map;
  logic [3:0] flags;
  logic       fz, fc, fv, fn;
  logic       cond_pass;
  logic       needs_flags;
  logic       flags_ready;
  logic       bypass;
  logic       cnt_inc;
  logic       cnt_dec;

  // EXE bus order {N,V,C,Z} placed into architectural order {N,V,C,Z} = bits 3..0
  assign exe_map[0] = exe_flags[0];
  assign exe_map[1] = exe_flags[1];
  assign exe_map[2] = exe_flags[2];
  assign exe_map[3] = exe_flags[3];

  // The last outstanding writer committing this cycle is forwarded straight to the condition check
  assign bypass = exe_flags_valid && (pending_cnt == 2'd1);
  assign flags  = bypass ? exe_map : status_reg;
  assign fz = flags[0];
  assign fc = flags[1];
  assign fv = flags[2];
  assign fn = flags[3];

  always_comb begin
    cond_pass = 1'b1;
    case (id_cond)
      4'b0000: cond_pass = fz;
      4'b0001: cond_pass = ~fz;
      4'b0010: cond_pass = fc;
      4'b0011: cond_pass = ~fc;
      4'b0100: cond_pass = fn;
      4'b0101: cond_pass = ~fn;
      4'b0110: cond_pass = fv;
      4'b0111: cond_pass = ~fv;
      4'b1000: cond_pass = fc & ~fz;
      4'b1001: cond_pass = ~fc | fz;
      4'b1010: cond_pass = (fn == fv);
      4'b1011: cond_pass = (fn != fv);
      4'b1100: cond_pass = ~fz & (fn == fv);
      4'b1101: cond_pass = fz | (fn != fv);
      default: cond_pass = 1'b1;
    endcase
  end

  assign needs_flags = (id_cond[3:1] != 3'b111);
  assign flags_ready = (pending_cnt == 2'd0) || bypass;

  always_comb begin
    state_nxt    = state;
    stall        = 1'b0;
    issue        = 1'b0;
    exec_en      = 1'b0;
    branch_taken = 1'b0;
    flush        = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (id_valid) begin
            stall   = hz_stall | (needs_flags & ~flags_ready) | (id_s & (pending_cnt == 2'd3));
            issue   = ~stall;
            exec_en = issue & cond_pass;
            if (issue && id_is_branch && cond_pass) begin
              branch_taken = 1'b1;
              flush        = 1'b1;
              state_nxt    = FLUSH;
            end else if (needs_flags && !flags_ready && !hz_stall) begin
              state_nxt = WAIT;
            end
          end
        end
        WAIT: begin
          stall = 1'b1;
          if (flags_ready) state_nxt = RUN;
        end
        FLUSH: begin
          flush     = 1'b1;
          state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign cnt_inc = issue & id_s & cond_pass;
  assign cnt_dec = exe_flags_valid & (pending_cnt != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      status_reg  <= 4'd0;
      pending_cnt <= 2'd0;
    end else begin
      state <= state_nxt;
      if (exe_flags_valid) status_reg <= exe_map;
      case ({cnt_inc, cnt_dec})
        2'b10:   pending_cnt <= pending_cnt + 2'd1;
        2'b01:   pending_cnt <= pending_cnt - 2'd1;
        default: pending_cnt <= pending_cnt;
      endcase
    end
  end

  // A commit with nothing outstanding means the pipeline and this scoreboard disagree
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(exe_flags_valid && pending_cnt == 2'd0));
  a_flush_stall_excl: assert property (@(posedge clk) !(flush && stall));

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// Directed bench for cond_exec_ctrl: inputs change 1 ns after posedge, outputs checked at negedge.
module tb_cond_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_cond;
  logic       id_s;
  logic       id_is_branch;
  logic       hz_stall;
  logic       exe_flags_valid;
  logic [3:0] exe_flags;
  logic [3:0] status_reg;
  logic       stall;
  logic       issue;
  logic       exec_en;
  logic       branch_taken;
  logic       flush;
  logic [1:0] pending_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] exp_tbl;

  cond_exec_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_cond         (id_cond),
    .id_s            (id_s),
    .id_is_branch    (id_is_branch),
    .hz_stall        (hz_stall),
    .exe_flags_valid (exe_flags_valid),
    .exe_flags       (exe_flags),
    .status_reg      (status_reg),
    .stall           (stall),
    .issue           (issue),
    .exec_en         (exec_en),
    .branch_taken    (branch_taken),
    .flush           (flush),
    .pending_cnt     (pending_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic s, input logic b,
                       input logic hz, input logic ev, input logic [3:0] ef);
    id_valid        = v;
    id_cond         = c;
    id_s            = s;
    id_is_branch    = b;
    hz_stall        = hz;
    exe_flags_valid = ev;
    exe_flags       = ef;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    tick();
    settle();
    chk("rst_issue", 4'(issue), 4'd0);
    chk("rst_stall", 4'(stall), 4'd0);
    tick();
    chk("rst_status", status_reg, 4'h0);
    chk("rst_pending", 4'(pending_cnt), 4'd0);

    // Condition EQ fails with Z=0: issues, no execute
    rst = 1'b0;
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    settle();
    chk("eq_fail_issue", 4'(issue), 4'd1);
    chk("eq_fail_exec", 4'(exec_en), 4'd0);
    chk("eq_fail_stall", 4'(stall), 4'd0);
    tick();

    // ADDS then MOVEQ waits for its flags
    drive(1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    settle();
    chk("adds_exec", 4'(exec_en), 4'd1);
    tick();
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    settle();
    chk("moveq_pend", 4'(pending_cnt), 4'd1);
    chk("moveq_stall", 4'(stall), 4'd1);
    chk("moveq_noissue", 4'(issue), 4'd0);
    tick();
    settle();
    chk("wait_stall", 4'(stall), 4'd1);
    tick();
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001);
    settle();
    chk("wait_commit_stall", 4'(stall), 4'd1);
    chk("wait_commit_issue", 4'(issue), 4'd0);
    tick();
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    settle();
    chk("after_wait_status", status_reg, 4'b0001);
    chk("after_wait_pend", 4'(pending_cnt), 4'd0);
    chk("moveq_issue", 4'(issue), 4'd1);
    chk("moveq_exec", 4'(exec_en), 4'd1);
    tick();

    // Bypass in RUN: MOVNE sees committing Z=0 instead of stale Z=1
    drive(1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    tick();
    drive(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    settle();
    chk("byp_stall", 4'(stall), 4'd0);
    chk("byp_issue", 4'(issue), 4'd1);
    chk("byp_exec", 4'(exec_en), 4'd1);
    tick();

    // Not-taken branch
    drive(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    settle();
    chk("bne_status", status_reg, 4'b0000);
    chk("bne_issue", 4'(issue), 4'd1);
    chk("bne_exec", 4'(exec_en), 4'd0);
    chk("bne_taken", 4'(branch_taken), 4'd0);
    chk("bne_flush", 4'(flush), 4'd0);
    tick();

    // Set Z=1, then taken BEQ
    drive(1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    tick();
    drive(1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001);
    tick();
    drive(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    settle();
    chk("beq_status", status_reg, 4'b0001);
    chk("beq_issue", 4'(issue), 4'd1);
    chk("beq_taken", 4'(branch_taken), 4'd1);
    chk("beq_flush", 4'(flush), 4'd1);
    chk("beq_stall", 4'(stall), 4'd0);
    tick();
    settle();
    chk("flush2_flush", 4'(flush), 4'd1);
    chk("flush2_issue", 4'(issue), 4'd0);
    chk("flush2_stall", 4'(stall), 4'd0);
    chk("flush2_taken", 4'(branch_taken), 4'd0);
    tick();
    drive(1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    settle();
    chk("post_flush_flush", 4'(flush), 4'd0);
    chk("post_flush_issue", 4'(issue), 4'd1);
    tick();

    // Three outstanding flag writers, fourth blocks
    drive(1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    tick();
    tick();
    tick();
    settle();
    chk("pend3", 4'(pending_cnt), 4'd3);
    chk("s4_stall", 4'(stall), 4'd1);
    chk("s4_issue", 4'(issue), 4'd0);
    tick();
    drive(1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    tick();
    drive(1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
    settle();
    chk("pend2", 4'(pending_cnt), 4'd2);
    chk("incdec_issue", 4'(issue), 4'd1);
    tick();
    drive(1'b1, 4'b1110, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    settle();
    chk("incdec_pend", 4'(pending_cnt), 4'd2);
    chk("hz_stall", 4'(stall), 4'd1);
    chk("hz_issue", 4'(issue), 4'd0);
    tick();

    // Reset in the middle of a flush
    drive(1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    tick();
    drive(1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001);
    tick();
    drive(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    settle();
    chk("rf_beq_flush", 4'(flush), 4'd1);
    tick();
    rst = 1'b1;
    settle();
    chk("rf_rst_flush", 4'(flush), 4'd0);
    tick();
    rst = 1'b0;
    drive(1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    settle();
    chk("rf_after_flush", 4'(flush), 4'd0);
    chk("rf_after_status", status_reg, 4'h0);
    chk("rf_after_pend", 4'(pending_cnt), 4'd0);
    chk("rf_after_issue", 4'(issue), 4'd1);
    tick();

    // Full condition table with NZCV = 0000
    exp_tbl = 16'hD6AA;
    for (int c = 0; c < 16; c++) begin
      drive(1'b1, 4'(c), 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      settle();
      chk($sformatf("cond0_%0d", c), 4'(exec_en), 4'(exp_tbl[c]));
      tick();
    end

    // Full condition table with N=1, C=1
    drive(1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    tick();
    drive(1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1010);
    tick();
    exp_tbl = 16'hE996;
    for (int c = 0; c < 16; c++) begin
      drive(1'b1, 4'(c), 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      settle();
      chk($sformatf("condNC_%0d", c), 4'(exec_en), 4'(exp_tbl[c]));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
